// File: rtl/psram_rd_capture.sv
// psram_rd_capture: DQS-oversampled PSRAM read capture, MSB-first 64-bit packing, word FIFO with valid/ready drain.
// Optional DQS timeout abort enabled by defining PSRAM_RD_TMO_EN.
module psram_rd_capture #(
  parameter int FIFO_DEPTH = 2,
  parameter int TMO_WIDTH  = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [3:0]           len_i,
  input  logic                 dqs_i,
  input  logic [7:0]           dq_i,
  input  logic [TMO_WIDTH-1:0] tmo_i,
  output logic                 busy_o,
  output logic [63:0]          data_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic                 ovf_o,
  output logic                 tmo_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, CAPT, PUSH} state_t;
  state_t      r_state;
  logic        r_dqs_q, r_dqs_qq;
  logic [7:0]  r_dq_q;
  logic [3:0]  r_len, r_idx;
  logic [63:0] r_word;
  logic        r_ovf, r_tmo;
  logic [63:0] r_mem [FIFO_DEPTH];
  logic [AW:0] r_wp, r_rp;
  logic        w_edge, w_empty, w_full, w_pop, w_push, w_last, w_abort;
  logic [5:0]  w_sh;
  assign w_edge  = r_dqs_q ^ r_dqs_qq;
  assign w_last  = (r_idx + 4'd1) == r_len;
  // 7-idx equals ~idx in three bits, so the byte lane offset is just the inverted index times 8
  assign w_sh    = {~r_idx[2:0], 3'b000};
  assign w_empty = r_wp == r_rp;
  assign w_full  = (r_wp[AW] != r_rp[AW]) && (r_wp[AW-1:0] == r_rp[AW-1:0]);
  assign w_pop   = !w_empty && ready_i;
  assign w_push  = (r_state == PUSH) && (!w_full || w_pop);
  assign busy_o  = r_state != IDLE;
  assign valid_o = !w_empty;
  assign data_o  = w_empty ? 64'd0 : r_mem[r_rp[AW-1:0]];
  assign ovf_o   = r_ovf;
  assign tmo_o   = r_tmo;
`ifdef PSRAM_RD_TMO_EN
  logic [TMO_WIDTH-1:0] r_tmo_cnt;
  assign w_abort = (r_state == CAPT) && !w_edge && (tmo_i != '0) && (r_tmo_cnt == tmo_i - TMO_WIDTH'(1));
  always_ff @(posedge clk_i)
    if (rst_i || r_state != CAPT || w_edge) r_tmo_cnt <= '0;
    else r_tmo_cnt <= r_tmo_cnt + TMO_WIDTH'(1);
`else
  logic w_unused;
  assign w_unused = ^tmo_i;
  assign w_abort  = 1'b0;
`endif
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state  <= IDLE;
      r_dqs_q  <= 1'b0;
      r_dqs_qq <= 1'b0;
      r_dq_q   <= '0;
      r_len    <= '0;
      r_idx    <= '0;
      r_word   <= '0;
      r_ovf    <= 1'b0;
      r_tmo    <= 1'b0;
      r_wp     <= '0;
      r_rp     <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
    end else begin
      r_dqs_q  <= dqs_i;
      r_dqs_qq <= r_dqs_q;
      r_dq_q   <= dq_i;
      case (r_state)
        IDLE: if (start_i) begin
          r_state <= CAPT;
          r_len   <= (len_i == 4'd0 || len_i > 4'd8) ? 4'd8 : len_i;
          r_idx   <= '0;
          r_word  <= '0;
          r_ovf   <= 1'b0;
          r_tmo   <= 1'b0;
        end
        CAPT: if (w_abort) begin
          r_state <= IDLE;
          r_tmo   <= 1'b1;
        end else if (w_edge) begin
          r_word[w_sh +: 8] <= r_dq_q;
          r_idx             <= r_idx + 4'd1;
          if (w_last) r_state <= PUSH;
        end
        PUSH: begin
          r_state <= IDLE;
          if (w_full && !w_pop) r_ovf <= 1'b1;
        end
        default: r_state <= IDLE;
      endcase
      if (w_push) begin
        r_mem[r_wp[AW-1:0]] <= r_word;
        r_wp                <= r_wp + (AW+1)'(1);
      end
      if (w_pop) r_rp <= r_rp + (AW+1)'(1);
    end
  end
endmodule

// File: tb/tb_psram_rd_capture.sv
// tb_psram_rd_capture: directed stimulus with a queue scoreboard; a negedge monitor checks every popped word.
module tb_psram_rd_capture;
  logic        clk = 1'b0;
  logic        rst, start, dqs, ready, busy, valid, ovf, tmo_f;
  logic [3:0]  len;
  logic [7:0]  dq, tmo;
  logic [63:0] data;
  logic [63:0] exp_q[$];
  int          n_tests = 0, n_fail = 0;

  always #5 clk = ~clk;

  psram_rd_capture #(.FIFO_DEPTH(2), .TMO_WIDTH(8)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .len_i(len), .dqs_i(dqs), .dq_i(dq),
    .tmo_i(tmo), .busy_o(busy), .data_o(data), .valid_o(valid), .ready_i(ready),
    .ovf_o(ovf), .tmo_o(tmo_f)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk)
    if (!rst && valid && ready) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_pop: got %h expected no word", data);
      end else chk("pop", data, exp_q.pop_front());
    end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic dqs_edge(input logic [7:0] b);
    dq  = b;
    dqs = ~dqs;
    tick(2);
  endtask

  task automatic capture(input logic [3:0] l, input logic [63:0] bytes, input int n);
    start = 1'b1;
    len   = l;
    tick();
    start = 1'b0;
    for (int i = 0; i < n; i++) dqs_edge(bytes[63-8*i -: 8]);
  endtask

  task automatic wait_idle(input string name);
    int k = 0;
    while (busy && k < 20) begin
      tick();
      k++;
    end
    chk(name, 64'(busy), 64'd0);
  endtask

  task automatic drain(input string name);
    int k = 0;
    while (exp_q.size() != 0 && k < 50) begin
      tick();
      k++;
    end
    chk(name, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; len = '0; dqs = 1'b0; dq = '0; ready = 1'b1; tmo = '0;
    tick(3);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_valid", 64'(valid), 64'd0);
    chk("rst_data", data, 64'd0);
    chk("rst_ovf", 64'(ovf), 64'd0);
    chk("rst_tmo", 64'(tmo_f), 64'd0);
    rst = 1'b0;
    tick(2);
    // full 8-byte word
    exp_q.push_back(64'h1122334455667788);
    capture(4'd8, 64'h1122334455667788, 8);
    wait_idle("t1_idle");
    drain("t1_drain");
    chk("t1_valid_after", 64'(valid), 64'd0);
    // edges while idle must capture nothing
    dqs_edge(8'h55);
    dqs_edge(8'h66);
    tick(3);
    chk("idle_edges_valid", 64'(valid), 64'd0);
    chk("idle_edges_busy", 64'(busy), 64'd0);
    // short word, len=0 means 8, len=12 saturates to 8
    exp_q.push_back(64'hA1B2C30000000000);
    capture(4'd3, 64'hA1B2C30000000000, 3);
    wait_idle("t2_len3_idle");
    drain("t2_len3_drain");
    exp_q.push_back(64'h0102030405060708);
    capture(4'd0, 64'h0102030405060708, 8);
    wait_idle("t2_len0_idle");
    drain("t2_len0_drain");
    exp_q.push_back(64'hF0E0D0C0B0A09080);
    capture(4'd12, 64'hF0E0D0C0B0A09080, 8);
    wait_idle("t2_len12_idle");
    drain("t2_len12_drain");
    // overflow with consumer stalled
    ready = 1'b0;
    exp_q.push_back(64'hDE00000000000000);
    exp_q.push_back(64'hAD00000000000000);
    capture(4'd1, 64'hDE00000000000000, 1);
    wait_idle("t3_a_idle");
    capture(4'd1, 64'hAD00000000000000, 1);
    wait_idle("t3_b_idle");
    chk("t3_no_ovf_yet", 64'(ovf), 64'd0);
    capture(4'd1, 64'hBE00000000000000, 1);
    wait_idle("t3_c_idle");
    tick();
    chk("t3_valid", 64'(valid), 64'd1);
    chk("t3_ovf", 64'(ovf), 64'd1);
    chk("t3_head", data, 64'hDE00000000000000);
    ready = 1'b1;
    drain("t3_drain");
    tick(2);
    chk("t3_empty", 64'(valid), 64'd0);
    chk("t3_ovf_sticky", 64'(ovf), 64'd1);
    // DQS stalls after 2 of 4 edges
    tmo = 8'd10;
    capture(4'd4, 64'h1234567800000000, 2);
    chk("t4_ovf_cleared", 64'(ovf), 64'd0);
`ifdef PSRAM_RD_TMO_EN
    tick(15);
    chk("t4_tmo", 64'(tmo_f), 64'd1);
    chk("t4_busy", 64'(busy), 64'd0);
    chk("t4_valid", 64'(valid), 64'd0);
    tmo = 8'd0;
    capture(4'd4, 64'h1234567800000000, 2);
    chk("t4_tmo_cleared", 64'(tmo_f), 64'd0);
`endif
    tick(30);
    chk("t4_wait_busy", 64'(busy), 64'd1);
    chk("t4_wait_tmo", 64'(tmo_f), 64'd0);
    exp_q.push_back(64'h1234567800000000);
    dqs_edge(8'h56);
    dqs_edge(8'h78);
    wait_idle("t4_idle");
    drain("t4_drain");
    // reset mid-capture with a word parked in the FIFO
    ready = 1'b0;
    capture(4'd1, 64'h7700000000000000, 1);
    wait_idle("t5_park_idle");
    tick();
    chk("t5_parked", 64'(valid), 64'd1);
    capture(4'd8, 64'h99AABBCCDDEEFF00, 3);
    chk("t5_mid_busy", 64'(busy), 64'd1);
    rst = 1'b1;
    tick();
    chk("t5_busy", 64'(busy), 64'd0);
    chk("t5_valid", 64'(valid), 64'd0);
    chk("t5_data", data, 64'd0);
    chk("t5_ovf", 64'(ovf), 64'd0);
    chk("t5_tmo", 64'(tmo_f), 64'd0);
    rst = 1'b0;
    ready = 1'b1;
    tick(3);
    chk("t5_post_valid", 64'(valid), 64'd0);
    exp_q.push_back(64'h99AABBCCDDEEFF00);
    capture(4'd8, 64'h99AABBCCDDEEFF00, 8);
    wait_idle("t5_idle");
    drain("t5_drain");
    // a second start during capture is ignored
    exp_q.push_back(64'hCAFEBABEDEADBEEF);
    start = 1'b1;
    len = 4'd8;
    tick();
    start = 1'b0;
    dqs_edge(8'hCA);
    dqs_edge(8'hFE);
    start = 1'b1;
    len = 4'd1;
    tick();
    start = 1'b0;
    chk("t6_busy", 64'(busy), 64'd1);
    dqs_edge(8'hBA);
    dqs_edge(8'hBE);
    dqs_edge(8'hDE);
    dqs_edge(8'hAD);
    dqs_edge(8'hBE);
    dqs_edge(8'hEF);
    wait_idle("t6_idle");
    drain("t6_drain");
    tick(2);
    chk("end_valid", 64'(valid), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
